// File: rtl/eeprom_page_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : eeprom_page_ctrl
// Description : Page-write / random-read controller for a small non-volatile
//               array model. A session opens with start, collects bytes into
//               a page buffer with wr, and closes with commit. Commit then
//               runs a timed internal program cycle, during which busy is
//               high. Only the bytes written during the session are
//               programmed. In IDLE, rd returns one array word one cycle
//               later.
//
//               Optional feature macro: EEPROM_WRITE_PROTECT_EN
//                 When defined, input wp exists. A commit issued while wp is
//                 high discards the buffer, pulses nack and never programs.
//
// Ports       : clk      - sole clock, rising edge
//               rst      - synchronous active-high reset (array untouched)
//               start    - open a page-write session at row/col
//               wr       - buffer data_i at the current byte pointer
//               commit   - close the session and start programming
//               rd       - random read at row/col
//               wp       - write protect (only with EEPROM_WRITE_PROTECT_EN)
//               row      - page address, sampled on start and rd
//               col      - byte address, sampled on start and rd
//               data_i   - write data, sampled on wr
//               data_o   - registered read data
//               rd_valid - one-cycle pulse, data_o valid
//               busy     - high during the internal program cycle
//               nack     - one-cycle pulse, request refused
//
// Revision    : 1.0 - initial release
// ============================================================================

module eeprom_page_ctrl #(
    parameter  int PAGE_NUM   = 32,
    parameter  int PAGE_BYTES = 8,
    parameter  int DATA_W     = 8,
    parameter  int TWR_CYCLES = 16,
    localparam int RW         = $clog2(PAGE_NUM),
    localparam int CW         = $clog2(PAGE_BYTES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              wr,
    input  logic              commit,
    input  logic              rd,
`ifdef EEPROM_WRITE_PROTECT_EN
    input  logic              wp,
`endif
    input  logic [RW-1:0]     row,
    input  logic [CW-1:0]     col,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o,
    output logic              rd_valid,
    output logic              busy,
    output logic              nack
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_LOAD = 2'd1;
    localparam logic [1:0] c_ST_PROG = 2'd2;

    localparam int c_CNT_W = (TWR_CYCLES > 1) ? $clog2(TWR_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(TWR_CYCLES - 1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [1:0]                           r_state_q,    w_state_d;
    logic [RW-1:0]                        r_page_q,     w_page_d;
    logic [CW-1:0]                        r_ptr_q,      w_ptr_d;
    logic [PAGE_BYTES-1:0]                r_mask_q,     w_mask_d;
    logic [PAGE_BYTES-1:0][DATA_W-1:0]    r_buf_q,      w_buf_d;
    logic [c_CNT_W-1:0]                   r_cnt_q,      w_cnt_d;
    logic [DATA_W-1:0]                    r_data_o_q,   w_data_o_d;
    logic                                 r_rd_valid_q, w_rd_valid_d;
    logic                                 r_nack_q,     w_nack_d;

    // Non-volatile array: deliberately outside the reset domain.
    logic [DATA_W-1:0] r_mem [PAGE_NUM][PAGE_BYTES];

    // ------------------------------------------------------------------------
    // Request qualification
    // ------------------------------------------------------------------------
    logic                  w_wp;
    logic                  w_row_ok;
    logic                  w_in_idle;
    logic                  w_in_load;
    logic                  w_start_go;
    logic                  w_rd_go;
    logic                  w_wr_en;
    logic                  w_commit_en;
    logic                  w_wp_refuse;
    logic [PAGE_BYTES-1:0] w_mask_upd;
    logic                  w_prog_done;

`ifdef EEPROM_WRITE_PROTECT_EN
    assign w_wp = wp;
`else
    assign w_wp = 1'b0;
`endif

    assign w_row_ok    = (32'(row) < 32'(PAGE_NUM));
    assign w_in_idle   = (r_state_q == c_ST_IDLE);
    assign w_in_load   = (r_state_q == c_ST_LOAD);
    // start has priority over rd when both arrive in IDLE.
    assign w_start_go  = w_in_idle && start && w_row_ok;
    assign w_rd_go     = w_in_idle && rd && !start && w_row_ok;
    assign w_wr_en     = w_in_load && wr;
    assign w_commit_en = w_in_load && commit;
    assign w_wp_refuse = w_commit_en && w_wp;
    // Mask as it stands after this cycle's wr, so a wr coinciding with
    // commit is part of the programmed page.
    assign w_mask_upd  = r_mask_q |
                         (w_wr_en ? (PAGE_BYTES'(1) << r_ptr_q) : '0);
    assign w_prog_done = (r_state_q == c_ST_PROG) && (r_cnt_q == '0);

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q    <= c_ST_IDLE;
            r_page_q     <= '0;
            r_ptr_q      <= '0;
            r_mask_q     <= '0;
            r_cnt_q      <= '0;
            r_data_o_q   <= '0;
            r_rd_valid_q <= 1'b0;
            r_nack_q     <= 1'b0;
        end else begin
            r_state_q    <= w_state_d;
            r_page_q     <= w_page_d;
            r_ptr_q      <= w_ptr_d;
            r_mask_q     <= w_mask_d;
            r_cnt_q      <= w_cnt_d;
            r_data_o_q   <= w_data_o_d;
            r_rd_valid_q <= w_rd_valid_d;
            r_nack_q     <= w_nack_d;
        end
    end

    // Buffer contents are only meaningful where the mask is set, so the
    // buffer itself needs no reset.
    always_ff @(posedge clk) begin
        r_buf_q <= w_buf_d;
    end

    // Program the masked bytes on the last PROG cycle. A reset on that very
    // cycle aborts the session, so it also blocks the write.
    always_ff @(posedge clk) begin
        if (!rst && w_prog_done) begin
            for (int i = 0; i < PAGE_BYTES; i++) begin
                if (r_mask_q[i]) begin
                    r_mem[r_page_q][i] <= r_buf_q[i];
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_d = r_state_q;
        case (r_state_q)
            c_ST_IDLE: begin
                if (w_start_go) begin
                    w_state_d = c_ST_LOAD;
                end
            end
            c_ST_LOAD: begin
                if (commit) begin
                    if (w_wp || (w_mask_upd == '0)) begin
                        w_state_d = c_ST_IDLE;
                    end else begin
                        w_state_d = c_ST_PROG;
                    end
                end
            end
            c_ST_PROG: begin
                if (r_cnt_q == '0) begin
                    w_state_d = c_ST_IDLE;
                end
            end
            default: begin
                w_state_d = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Output and datapath logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_page_d     = r_page_q;
        w_ptr_d      = r_ptr_q;
        w_mask_d     = r_mask_q;
        w_buf_d      = r_buf_q;
        w_cnt_d      = r_cnt_q;
        w_data_o_d   = r_data_o_q;
        w_rd_valid_d = 1'b0;
        // Any start or rd that was not served is refused.
        w_nack_d     = (start && !w_start_go) || (rd && !w_rd_go) ||
                       w_wp_refuse;

        case (r_state_q)
            c_ST_IDLE: begin
                if (w_start_go) begin
                    w_page_d = row;
                    w_ptr_d  = col;
                    w_mask_d = '0;
                end
                if (w_rd_go) begin
                    w_data_o_d   = r_mem[row][col];
                    w_rd_valid_d = 1'b1;
                end
            end
            c_ST_LOAD: begin
                if (wr) begin
                    w_buf_d[r_ptr_q] = data_i;
                    w_mask_d         = w_mask_upd;
                    // PAGE_BYTES is a power of two: natural wrap in page.
                    w_ptr_d          = r_ptr_q + CW'(1);
                end
                if (commit) begin
                    if (w_wp || (w_mask_upd == '0)) begin
                        w_mask_d = '0;
                    end else begin
                        w_cnt_d = c_CNT_LOAD;
                    end
                end
            end
            c_ST_PROG: begin
                if (r_cnt_q != '0) begin
                    w_cnt_d = r_cnt_q - c_CNT_W'(1);
                end else begin
                    w_mask_d = '0;
                end
            end
            default: begin
                w_mask_d = '0;
            end
        endcase
    end

    assign busy     = (r_state_q == c_ST_PROG);
    assign data_o   = r_data_o_q;
    assign rd_valid = r_rd_valid_q;
    assign nack     = r_nack_q;

endmodule

`default_nettype wire

// File: doc/eeprom_page_ctrl.md
EEPROM_PAGE_CTRL -- requirements
Module: eeprom_page_ctrl

Interface
REQ-001 Parameter PAGE_NUM, default 32, number of pages in the array.
REQ-002 Parameter PAGE_BYTES, default 8, bytes per page; power of two, at least 2.
REQ-003 Parameter DATA_W, default 8, width of one array word.
REQ-004 Parameter TWR_CYCLES, default 16, internal program time in clk cycles; at least 1.
REQ-005 Derived widths: RW = clog2(PAGE_NUM), CW = clog2(PAGE_BYTES).
REQ-006 clk  input  1  sole clock; all state updates on its rising edge.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 start  input  1  one-cycle pulse that opens a page-write session at row/col.
REQ-009 wr  input  1  one-cycle pulse that loads data_i into the page buffer.
REQ-010 commit  input  1  one-cycle pulse that closes the session and starts programming.
REQ-011 rd  input  1  one-cycle pulse requesting a random read at row/col.
REQ-012 row  input  RW  page address, sampled on start and rd.
REQ-013 col  input  CW  byte address within the page, sampled on start and rd.
REQ-014 data_i  input  DATA_W  write data, sampled on wr.
REQ-015 data_o  output  DATA_W  registered read data.
REQ-016 rd_valid  output  1  one-cycle pulse marking data_o valid.
REQ-017 busy  output  1  high while the internal program cycle runs.
REQ-018 nack  output  1  one-cycle pulse when a request is refused.

Function
REQ-019 The FSM SHALL have three states: IDLE, LOAD and PROG.
REQ-020 In IDLE, start SHALL latch row into page_reg and col into ptr, clear the byte mask, and go to LOAD.
REQ-021 In LOAD, wr SHALL store data_i into buffer[ptr], set mask[ptr], and advance ptr modulo PAGE_BYTES; wrap stays within the page and overwrites earlier buffered bytes.
REQ-022 In LOAD, commit with a nonzero mask SHALL load the counter with TWR_CYCLES-1, assert busy the next cycle, and go to PROG.
REQ-023 In LOAD, commit with a zero mask SHALL return to IDLE with no array change.
REQ-024 If wr and commit arrive in the same LOAD cycle, the byte SHALL be buffered first and included in the program.
REQ-025 In PROG, the counter SHALL decrement each cycle; at zero, only the masked bytes SHALL be written to array[page_reg], and the FSM SHALL go to IDLE; busy SHALL be high for exactly TWR_CYCLES cycles.
REQ-026 Unmasked bytes of the programmed page SHALL keep their previous contents.
REQ-027 In IDLE, rd SHALL return array[row][col] on data_o, with rd_valid high, exactly 1 cycle later.
REQ-028 In IDLE, if start and rd arrive together, start SHALL win and rd SHALL be refused.
REQ-029 A refused request SHALL pulse nack the next cycle and change no state. Refused requests are:
- rd or start outside IDLE;
- rd in IDLE together with start.
REQ-030 wr or commit outside LOAD SHALL be ignored silently.
REQ-031 A row of PAGE_NUM or above, sampled on start or rd, SHALL be refused with nack.

Reset
REQ-032 rst SHALL force the following, regardless of state:
- state IDLE;
- busy, rd_valid and nack to 0;
- data_o to 0;
- mask, ptr, page_reg and counter to 0.
REQ-033 Array contents SHALL NOT be affected by rst (non-volatile model).
REQ-034 rst during LOAD or PROG SHALL abort the session; the array SHALL be left unchanged.

Configuration
REQ-035 With macro EEPROM_WRITE_PROTECT_EN defined, a 1-bit input wp SHALL exist; commit while wp is high SHALL discard the buffer, pulse nack, return to IDLE, and never assert busy.
REQ-036 Without EEPROM_WRITE_PROTECT_EN, no wp port SHALL exist and commit SHALL behave as in REQ-022 and REQ-023.

Verification
REQ-037 Page write: start(row=3,col=0), then wr 0x11..0x88 (8 bytes), then commit -> busy high for 16 cycles; afterwards rd(3,5) returns 0x66 with rd_valid 1 cycle after rd.
REQ-038 Wrap and partial write: start(row=4,col=6), then wr 0xA1,0xA2,0xA3 -> bytes 6,7,0 hold 0xA1,0xA2,0xA3; bytes 1..5 keep their prior values.
REQ-039 Busy refusal: rd(3,0) issued during PROG -> nack pulse, no rd_valid; the same rd after busy falls returns 0x11.
REQ-040 Simultaneous events: wr(0x5A) together with commit at ptr 2 -> byte 2 is programmed to 0x5A. start together with rd in IDLE -> LOAD entered and nack pulsed.
REQ-041 Reset abort: rst asserted on the 5th PROG cycle -> busy 0 next cycle; the page reads back its old contents.
REQ-042 With EEPROM_WRITE_PROTECT_EN and wp=1: commit -> nack, busy never rises, array unchanged.
